note_player: RTL and testbench



---
 rtl/note_player_pkg.sv | 35 +++
 rtl/note_player_tone_divider.sv | 37 +++
 rtl/note_player.sv | 161 ++++++++++++++++
 tb/tb_note_player.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared widths, note/length codes and octave-4 half-period table
package note_player_pkg;

    localparam int OCTAVE_BITS    = 3;
    localparam int NOTE_BITS      = 3;
    localparam int LENGTH_BITS    = 3;
    localparam int CLOCK_BITS     = 32;
    localparam int HALF_BITS      = 22;

    localparam int NOTE_REST      = 7;
    localparam int LENGTH_QUARTER = 2;

`ifdef NOTE_PLAYER_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY} state_e;
`endif

    // Octave-4 half periods at 100 MHz; the rest code maps to 0 and is clamped later.
    function automatic logic [HALF_BITS-1:0] base_half(input logic [2:0] code);
        logic [HALF_BITS-1:0] h;
        case (code)
            3'd0:    h = 22'd191113;
            3'd1:    h = 22'd170265;
            3'd2:    h = 22'd151685;
            3'd3:    h = 22'd143172;
            3'd4:    h = 22'd127551;
            3'd5:    h = 22'd113636;
            3'd6:    h = 22'd101239;
            default: h = 22'd0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/note_player_tone_divider.sv
// rtl/note_player_tone_divider.sv - square-wave generator toggling every half cycles while run is high
module tone_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [21:0] half,
    output logic        wave
);

    logic [21:0] cnt_q, cnt_d;
    logic        wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q + 22'd1;
        wave_d = wave_q;
        if (!run) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q >= half - 22'd1) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - plays one latched note on the buzzer; NOTE_PLAYER_GAP_EN adds a silent gap
module note_player #(
    parameter int OCTAVE_BITS  = note_player_pkg::OCTAVE_BITS,
    parameter int NOTE_BITS    = note_player_pkg::NOTE_BITS,
    parameter int LENGTH_BITS  = note_player_pkg::LENGTH_BITS,
    parameter int CLOCK_BITS   = note_player_pkg::CLOCK_BITS,
    parameter int DIV_SHIFT    = 0,
    parameter int DEFAULT_BEAT = 25000000,
    parameter int GAP_CYCLES   = 2500000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [OCTAVE_BITS-1:0] octave,
    input  logic [NOTE_BITS-1:0]   note,
    input  logic [LENGTH_BITS-1:0] length,
    input  logic [CLOCK_BITS-1:0]  clock,
    output logic                   buzzer,
    output logic                   busy,
    output logic                   done
);

    import note_player_pkg::*;

    localparam int DUR_BITS = CLOCK_BITS + 2;

    state_e                    state_q, state_d;
    logic [DUR_BITS-1:0]       dur_q, dur_d, cnt_q, cnt_d;
    logic [HALF_BITS-1:0]      half_q, half_d;
    logic                      rest_q, rest_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic                      last_play, tone_run;

    logic [CLOCK_BITS-1:0]     beat;
    logic [LENGTH_BITS-1:0]    len_shift;
    logic [DUR_BITS-1:0]       dur_calc;
    logic [HALF_BITS-1:0]      half_calc;

`ifdef NOTE_PLAYER_GAP_EN
    logic [31:0]               gap_q, gap_d;
`else
    logic                      unused_gap_cfg;
    assign unused_gap_cfg = (GAP_CYCLES != 0);
`endif

    // Duration and pitch of the note presented at the inputs, used only on acceptance.
    always_comb begin
        beat      = (clock == '0) ? CLOCK_BITS'(DEFAULT_BEAT) : clock;
        len_shift = (length == LENGTH_BITS'(7)) ? LENGTH_BITS'(LENGTH_QUARTER) : length;
        dur_calc  = ({2'b00, beat} << 2) >> len_shift;
        if (dur_calc == '0) begin
            dur_calc = DUR_BITS'(1);
        end
        half_calc = ((base_half(3'(note)) << 4) >> octave) >> DIV_SHIFT;
        if (half_calc == '0) begin
            half_calc = HALF_BITS'(1);
        end
    end

    assign last_play = (state_q == ST_PLAY) && (cnt_q == dur_q - DUR_BITS'(1));
    assign tone_run  = (state_q == ST_PLAY) && !last_play && !rest_q && en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        half_d  = half_q;
        rest_d  = rest_q;
        done_d  = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                    dur_d   = dur_calc;
                    half_d  = half_calc;
                    rest_d  = (note == NOTE_BITS'(NOTE_REST));
                end
            end
            ST_PLAY: begin
                if (last_play) begin
                    cnt_d = '0;
`ifdef NOTE_PLAYER_GAP_EN
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    done_d  = (GAP_CYCLES == 0);
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + DUR_BITS'(1);
                end
            end
`ifdef NOTE_PLAYER_GAP_EN
            ST_GAP: begin
                if (gap_q == 32'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Disable wins over both a new start and a completing note.
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
            gap_d   = '0;
`endif
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dur_q   <= '0;
            half_q  <= '0;
            rest_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            rest_q  <= rest_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NOTE_PLAYER_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    tone_divider u_tone (
        .clk  (clk),
        .rst  (rst),
        .run  (tone_run),
        .half (half_q),
        .wave (buzzer)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - randomized and directed checks of note_player against a timeline model
module tb_note_player;

    localparam int DIVS = 10;
    localparam int DEFB = 400;
`ifdef NOTE_PLAYER_GAP_EN
    localparam int GAP = 20;
`else
    localparam int GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b1;
    logic [2:0]  octave = 3'd4;
    logic [2:0]  note = 3'd5;
    logic [2:0]  length = 3'd2;
    logic [31:0] clock = 32'd1000;
    logic        buzzer, busy, done;

    note_player #(
        .DIV_SHIFT    (DIVS),
        .DEFAULT_BEAT (DEFB),
        .GAP_CYCLES   (20)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .start  (start),
        .octave (octave),
        .note   (note),
        .length (length),
        .clock  (clock),
        .buzzer (buzzer),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;

    longint ecnt = 0;
    longint m_t0 = 0;
    longint m_dur = 1;
    longint m_half = 1;
    longint j_now;
    logic   m_active = 1'b0;
    logic   m_rest = 1'b0;
    logic   exp_buz = 1'b0;
    logic   exp_busy = 1'b0;
    logic   exp_done = 1'b0;

    function automatic longint f_half(input int oct, input int nt);
        longint base [8] = '{191113, 170265, 151685, 143172, 127551, 113636, 101239, 0};
        longint h;
        h = ((base[nt] * 16) >> oct) >> DIVS;
        if (h == 0) h = 1;
        return h;
    endfunction

    function automatic longint f_dur(input int len, input longint clkv);
        longint beat, d;
        int sh;
        beat = (clkv == 0) ? DEFB : clkv;
        sh = (len == 7) ? 2 : len;
        d = (beat * 4) >> sh;
        if (d == 0) d = 1;
        return d;
    endfunction

    // A note is a timeline from its acceptance edge: j edges later the outputs follow from j alone.
    assign j_now = ecnt + 1 - m_t0;

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (rst || !en) begin
            m_active <= 1'b0;
            exp_buz  <= 1'b0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else if (!m_active) begin
            exp_buz  <= 1'b0;
            exp_done <= 1'b0;
            exp_busy <= start;
            if (start) begin
                m_active <= 1'b1;
                m_t0     <= ecnt + 1;
                m_dur    <= f_dur(int'(length), longint'(clock));
                m_half   <= f_half(int'(octave), int'(note));
                m_rest   <= (note == 3'd7);
            end
        end else begin
            exp_busy <= (j_now < m_dur + GAP);
            exp_done <= (j_now == m_dur + GAP);
            exp_buz  <= !m_rest && (j_now < m_dur) && (((j_now / m_half) % 2) == 1);
            if (j_now == m_dur + GAP) m_active <= 1'b0;
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ecnt, act, expv);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("buzzer", longint'(buzzer), longint'(exp_buz));
        chk("busy", longint'(busy), longint'(exp_busy));
        chk("done", longint'(done), longint'(exp_done));
    endtask

    task automatic directed(input string tag, input int oct, input int nt, input int len,
                            input int clk_v, input int exp_half, input int exp_dur,
                            input int abort_at, input int dup_at);
        longint e0, k;
        int first_rise, done_cnt, done_off, busy_cnt;
        if (exp_half > 0) chk({tag, " model half"}, f_half(oct, nt), exp_half);
        chk({tag, " model dur"}, f_dur(len, clk_v), exp_dur);
        octave = 3'(oct);
        note   = 3'(nt);
        length = 3'(len);
        clock  = 32'(clk_v);
        start  = 1'b1;
        e0 = ecnt + 1;
        first_rise = -1;
        done_cnt = 0;
        done_off = -1;
        busy_cnt = 0;
        for (int n = 0; n < exp_dur + GAP + 60; n++) begin
            cycle();
            k = ecnt - e0;
            if (buzzer && first_rise < 0) first_rise = int'(k);
            if (done) begin
                done_cnt++;
                done_off = int'(k);
            end
            if (busy) busy_cnt++;
            if (n == 0) begin
                octave = 3'($urandom_range(0, 7));
                note   = 3'($urandom_range(0, 6));
                length = 3'($urandom_range(0, 7));
                clock  = 32'($urandom_range(1, 300));
            end
            start = (k + 1 == dup_at);
            if (k + 1 == dup_at) note = 3'd0;
            if (k + 1 == abort_at) en = 1'b0;
            if (k + 1 == abort_at + 4) en = 1'b1;
        end
        start = 1'b0;
        if (abort_at < 0) begin
            chk({tag, " done count"}, done_cnt, 1);
            chk({tag, " done offset"}, done_off, exp_dur + GAP);
            chk({tag, " busy cycles"}, busy_cnt, exp_dur + GAP);
        end else begin
            chk({tag, " done count"}, done_cnt, 0);
            chk({tag, " busy cycles"}, busy_cnt, abort_at);
        end
        chk({tag, " first rise"}, first_rise, (exp_half > 0) ? exp_half : -1);
    endtask

    initial begin
        // Reset held with start asserted: nothing may start and all outputs stay low.
        repeat (3) cycle();
        chk("reset done", longint'(done), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) cycle();

        chk("model quarter code7", f_dur(7, 100), 100);
        chk("model dur floor", f_dur(6, 1), 1);
        chk("model half C0", f_half(0, 0), 2986);

        directed("tone",  4, 5, 2, 1000, 110, 1000, -1, -1);
        directed("scale", 5, 5, 3, 1000,  55,  500, -1, -1);
        directed("rest",  4, 7, 0,    0,   0, 1600, -1, -1);
        directed("abort", 4, 5, 2, 1000, 110, 1000, 300, -1);
        directed("dup",   4, 5, 2, 1000, 110, 1000, -1, 50);

        for (int n = 0; n < 9000; n++) begin
            cycle();
            start  = ($urandom_range(0, 3) == 0);
            octave = 3'($urandom_range(0, 7));
            note   = 3'($urandom_range(0, 7));
            length = 3'($urandom_range(0, 7));
            clock  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 500));
            en     = ($urandom_range(0, 399) != 0);
            rst    = ($urandom_range(0, 999) == 0);
        end
        rst   = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
